cmul_sequencer: RTL

CMUL_SEQUENCER -- requirements
Module: cmul_sequencer

---
 rtl/cmul_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cmul_sequencer.sv
// Sequential complex multiplier: one shared unsigned WIDTH x WIDTH multiplier
// evaluates the four real partial products over four cycles.

module cmul_umul #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
endmodule

module cmul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] ar,
  input  logic signed [WIDTH-1:0] ai,
  input  logic signed [WIDTH-1:0] br,
  input  logic signed [WIDTH-1:0] bi,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [2*WIDTH:0] pr,
  output logic signed [2*WIDTH:0] pi,
  output logic                    busy
);
  localparam int PW = 2*WIDTH+1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic signed [WIDTH-1:0] ar_r, ai_r, br_r, bi_r;
  logic signed [WIDTH-1:0] op_a_s, op_b_s;
  logic [WIDTH-1:0]        mag_a_s, mag_b_s;
  logic [2*WIDTH-1:0]      prod_s;
  logic                    neg_s;
  logic signed [PW-1:0]    term_s;
  logic signed [PW-1:0]    pr_acc_r, pi_acc_r, pr_r, pi_r;
  logic                    in_ready_r, out_valid_r, busy_r;

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    if (x[WIDTH-1]) begin
      m = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = x;
    end
    return m;
  endfunction

  function automatic logic signed [PW-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                      input logic neg);
    logic [PW-1:0] e;
    e = {1'b0, p};
    if (neg) begin
      e = ~e + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      e = e;
    end
    return $signed(e);
  endfunction

  // Operand pair routed to the shared multiplier in each compute state
  always_comb begin
    op_a_s = ar_r;
    op_b_s = br_r;
    case (state_r)
      M1:      begin op_a_s = ai_r; op_b_s = bi_r; end
      M2:      begin op_a_s = ar_r; op_b_s = bi_r; end
      M3:      begin op_a_s = ai_r; op_b_s = br_r; end
      default: begin op_a_s = ar_r; op_b_s = br_r; end
    endcase
  end

  assign mag_a_s = magnitude(op_a_s);
  assign mag_b_s = magnitude(op_b_s);
  assign neg_s   = op_a_s[WIDTH-1] ^ op_b_s[WIDTH-1];
  assign term_s  = apply_sign(prod_s, neg_s);

  cmul_umul #(.WIDTH(WIDTH)) u_umul (
    .a (mag_a_s),
    .b (mag_b_s),
    .p (prod_s)
  );

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_s = M0;
          end else begin
            state_s = IDLE;
          end
        end
        M0:   state_s = M1;
        M1:   state_s = M2;
        M2:   state_s = M3;
        M3:   state_s = DONE;
        DONE: begin
          if (out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register and handshake flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Operand capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_r <= '0;
      ai_r <= '0;
      br_r <= '0;
      bi_r <= '0;
    end else if ((state_r == IDLE) && in_valid && !flush) begin
      ar_r <= ar;
      ai_r <= ai;
      br_r <= br;
      bi_r <= bi;
    end
  end

  // Accumulation; results are published only on the M3 -> DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_acc_r <= '0;
      pi_acc_r <= '0;
      pr_r     <= '0;
      pi_r     <= '0;
    end else if (!flush) begin
      case (state_r)
        M0: pr_acc_r <= term_s;
        M1: pr_acc_r <= pr_acc_r - term_s;
        M2: pi_acc_r <= term_s;
        M3: begin
          pi_acc_r <= pi_acc_r + term_s;
          pr_r     <= pr_acc_r;
          pi_r     <= pi_acc_r + term_s;
        end
        default: begin
          pr_acc_r <= pr_acc_r;
          pi_acc_r <= pi_acc_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign pr        = pr_r;
  assign pi        = pi_r;

endmodule
